// File: rtl/onehot_ring_counter_p_if.sv
// Control and status bundle for the one-hot ring counter.
// Signalling contract: there is no valid/ready pair here. EN, DIR, LOAD and
// LOAD_VAL are level inputs sampled on every rising CLK edge; Q, C, WRAP and
// ERR are always valid (C only meaningful while ERR is low).
interface onehot_ring_counter_p_if #(
   parameter int N = 16,
   parameter int W = 4
);
   logic           EN;
   logic           DIR;
   logic           LOAD;
   logic [W-1:0]   LOAD_VAL;
   logic [0:N-1]   Q;
   logic [0:W-1]   C;
   logic           WRAP;
   logic           ERR;

   modport master (
      output EN, DIR, LOAD, LOAD_VAL,
      input  Q, C, WRAP, ERR
   );

   modport slave (
      input  EN, DIR, LOAD, LOAD_VAL,
      output Q, C, WRAP, ERR
   );
endinterface

// File: rtl/onehot_ring_counter_p.sv
// N-position one-hot ring counter with up/down stepping, direct load,
// binary position encoder, wrap pulse and self-correction of illegal states.
module onehot_ring_counter_p #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   onehot_ring_counter_p_if.slave bus
);

   // Position 0 hot; Q[0] is the leftmost element of the [0:N-1] vector.
   localparam logic [0:N-1] RESET_Q = {1'b1, {(N-1){1'b0}}};
   // N as a W+1 bit value so that N == 2**W still compares correctly.
   localparam logic [W:0]   N_L     = (W+1)'(N);

   logic [0:N-1] q_q, q_d;
   logic         wrap_q, wrap_d;
   logic         err;
   logic [0:W-1] code;
   logic [0:N-1] load_hot;
   logic         load_ok;

   // Legality check: the ring must hold exactly one hot bit.
   always_comb begin
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (q_q[i]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
         end
      end
      err = !seen || multi;
   end

   // Encoder: C[k] ORs every ring bit whose index has weight-bit (W-1-k) set.
   always_comb begin
      code = '0;
      for (int k = 0; k < W; k++) begin
         for (int i = 0; i < N; i++) begin
            if (((i >> (W - 1 - k)) & 1) != 0) code[k] = code[k] | q_q[i];
         end
      end
   end

   // Decode LOAD_VAL into a one-hot pattern and flag out-of-range positions.
   always_comb begin
      load_ok = ({1'b0, bus.LOAD_VAL} < N_L);
      for (int i = 0; i < N; i++) begin
         load_hot[i] = (bus.LOAD_VAL == W'(i));
      end
   end

   // Next-state selection: recovery, then load, then stepping, else hold.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (err) begin
         q_d = RESET_Q;
      end else if (bus.LOAD) begin
         if (load_ok) q_d = load_hot;
      end else if (bus.EN) begin
         if (!bus.DIR) begin
            q_d    = {q_q[N-1], q_q[0:N-2]};
            wrap_d = q_q[N-1];
         end else begin
            q_d    = {q_q[1:N-1], q_q[0]};
            wrap_d = q_q[0];
         end
      end
   end

   // Ring and wrap-pulse registers, cleared asynchronously.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q    <= RESET_Q;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.Q    = q_q;
   assign bus.C    = code;
   assign bus.WRAP = wrap_q;
   assign bus.ERR  = err;

endmodule
